clock_display: RTL

- Reader side of the clock time bus: consumes binary sec/min/hour from the clock counter and drives the board's 8-digit common-anode 7-segment display as HH.MM.SS.
- Time is snapshotted once per scan frame so a frame never shows a mix of old and new values.
- Digits are multiplexed from a refresh divider.
- Supports blanking the whole display and blinking one field, which the set-time controls use.

---
 rtl/clock_display_if.sv | 22 ++
 rtl/clock_display.sv | 139 +++++++++++++
 2 files changed

// File: rtl/clock_display_if.sv
// Time bus from the clock counter plus the display pins of the 7-segment board.
// master = time source / board side, slave = clock_display.
interface clock_display_if;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic       display_en;
  logic [1:0] blink_sel;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output sec, min, hour, display_en, blink_sel,
    input  an, seg, dp
  );

  modport slave (
    input  sec, min, hour, display_en, blink_sel,
    output an, seg, dp
  );
endinterface

// File: rtl/clock_display.sv
// Multiplexed HH.MM.SS driver for an 8-digit common-anode display.
// Time is snapshotted once per scan frame so a frame is never torn.

module clock_display_field (
  input  logic [7:0] val_i,
  output logic [6:0] ones_seg_o,
  output logic [6:0] tens_seg_o
);
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens = 4'(val_i / 8'd10);
    ones = 4'(val_i % 8'd10);
    // Values that cannot be two decimal digits show dashes on both.
    if (val_i > 8'd99) begin
      ones_seg_o = 7'h3F;
      tens_seg_o = 7'h3F;
    end else begin
      ones_seg_o = seg7(ones);
      tens_seg_o = seg7(tens);
    end
  end
endmodule

module clock_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int NUM_DIGITS  = 6
) (
  input  logic           clk_100MHz,
  input  logic           reset,
  clock_display_if.slave disp
);
  localparam int NUM_FIELDS = 3;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [RW-1:0] refresh_q, refresh_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [NUM_FIELDS-1:0][7:0] snap_q, snap_d;  // 0 = sec, 1 = min, 2 = hour
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [2*NUM_FIELDS-1:0][6:0] dig_seg;
  logic [1:0] fld;
  logic       blank;

  genvar g;
  generate
    for (g = 0; g < NUM_FIELDS; g++) begin : g_fld
      clock_display_field u_fld (
        .val_i      (snap_q[g]),
        .ones_seg_o (dig_seg[2*g]),
        .tens_seg_o (dig_seg[2*g+1])
      );
    end
  endgenerate

  // Scan timing, frame snapshot and blink phase.
  always_comb begin
    refresh_d   = refresh_q + 1'b1;
    idx_d       = idx_q;
    snap_d      = snap_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        snap_d = {disp.hour, disp.min, disp.sec};
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // Pin drive for the digit currently indexed; lands one clock later.
  always_comb begin
    fld   = idx_q[2:1];
    blank = blink_ph_q && (disp.blink_sel != 2'd0) && (disp.blink_sel == fld + 2'd1);
    seg_d = blank ? 7'h7F : dig_seg[idx_q];
    dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
    an_d  = 8'hFF;
    if (disp.display_en) an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      refresh_q   <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      snap_q      <= '0;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      refresh_q   <= refresh_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;
endmodule
